// File: rtl/mips_mem_arbiter.sv
// Two-port bus arbiter for a MIPS core: instruction fetch and load/store share one memory bus.
// Data wins contested grants until fetch has lost STARVE_LIMIT in a row, then fetch is served once.
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [31:0]       instr_rdata,
    output logic              instr_done,
    // load/store port
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_byteenable,
    output logic [31:0]       data_rdata,
    output logic              data_done,
    // memory bus
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    // debug view of the arbiter FSM
    output logic [1:0]        state_dbg
);

    // Handshake: a request is a level, sampled only while IDLE; the granted transfer sits on
    // the bus until the first cycle with mem_waitrequest=0, and the port's done pulses in the
    // following cycle. A request still high in its done cycle is taken as a new request.

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INSTR_XFER = 2'd1,
        DATA_XFER  = 2'd2
    } state_t;

    localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                instr_done_q, instr_done_d;
    logic                data_done_q, data_done_d;
    logic [31:0]         instr_rdata_q, instr_rdata_d;
    logic [31:0]         data_rdata_q, data_rdata_d;

    logic instr_pend;
    logic data_pend;
    logic xfer;

    assign instr_pend = instr_req;
    assign data_pend  = data_read | data_write;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        instr_done_d  = 1'b0;
        data_done_d   = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (instr_pend && (!data_pend || cnt_q == CNT_MAX)) begin
                    state_d = INSTR_XFER;
                    addr_d  = instr_addr;
                    wdata_d = '0;
                    be_d    = 4'hF;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end else if (data_pend) begin
                    state_d = DATA_XFER;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    be_d    = data_byteenable;
                    // a simultaneous read+write is served as the write alone
                    wr_d    = data_write;
                    if (instr_pend && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            INSTR_XFER: begin
                if (!mem_waitrequest) begin
                    state_d       = IDLE;
                    instr_done_d  = 1'b1;
                    instr_rdata_d = mem_readdata;
                end
            end
            DATA_XFER: begin
                if (!mem_waitrequest) begin
                    state_d     = IDLE;
                    data_done_d = 1'b1;
                    if (!wr_q) begin
                        data_rdata_d = mem_readdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            instr_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            instr_done_q  <= instr_done_d;
            data_done_q   <= data_done_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    // Bus is driven purely from the latched transfer, so it cannot move during wait states.
    assign xfer           = (state_q != IDLE);
    assign mem_address    = xfer ? addr_q  : '0;
    assign mem_writedata  = xfer ? wdata_q : '0;
    assign mem_byteenable = xfer ? be_q    : '0;
    assign mem_read       = xfer && !wr_q;
    assign mem_write      = xfer && wr_q;

    assign instr_done  = instr_done_q;
    assign data_done   = data_done_q;
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model with a bus/done scoreboard.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

    localparam int STARVE = 3;
    localparam int AW     = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_req = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic [31:0]   instr_rdata;
    logic          instr_done;
    logic          data_read = 1'b0;
    logic          data_write = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic [3:0]    data_byteenable = '0;
    logic [31:0]   data_rdata;
    logic          data_done;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_readdata = '0;
    logic          mem_waitrequest = 1'b0;
    logic [1:0]    state_dbg;

    mips_mem_arbiter #(.STARVE_LIMIT(STARVE), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_rdata(instr_rdata), .instr_done(instr_done),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_rdata(data_rdata), .data_done(data_done),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req       = 1'b0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk32({tag, "_mem_addr"}, mem_address, 32'h0);
        chk1({tag, "_instr_done"}, instr_done, 1'b0);
        chk1({tag, "_data_done"}, data_done, 1'b0);
        chk32({tag, "_instr_rdata"}, instr_rdata, 32'h0);
        chk32({tag, "_data_rdata"}, data_rdata, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        chk_quiet("reset");
        reset = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        instr;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        logic [31:0] exp_port_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        instr_req       = v.instr;
        instr_addr      = v.addr;
        data_read       = v.rd;
        data_write      = v.wr;
        data_addr       = v.addr;
        data_wdata      = v.wdata;
        data_byteenable = v.be;
        mem_waitrequest = 1'b1;
        chk1({t, "_idle_read"}, mem_read, 1'b0);
        chk1({t, "_idle_write"}, mem_write, 1'b0);
        step();
        for (int k = 0; k <= v.waits; k++) begin
            mem_waitrequest = (k < v.waits);
            mem_readdata    = (k == v.waits) ? v.rdata : $urandom();
            chk1({t, "_bus_read"}, mem_read, v.exp_rd);
            chk1({t, "_bus_write"}, mem_write, v.exp_wr);
            chk32({t, "_bus_addr"}, mem_address, v.addr);
            chk32({t, "_bus_be"}, 32'(mem_byteenable), 32'(v.exp_be));
            if (v.exp_wr) chk32({t, "_bus_wdata"}, mem_writedata, v.wdata);
            chk1({t, "_early_idone"}, instr_done, 1'b0);
            chk1({t, "_early_ddone"}, data_done, 1'b0);
            // requester inputs wander while the transfer is in flight; they must be ignored
            instr_addr      = $urandom();
            data_addr       = $urandom();
            data_wdata      = $urandom();
            data_byteenable = 4'($urandom());
            step();
        end
        clear_inputs();
        chk1({t, "_instr_done"}, instr_done, v.instr);
        chk1({t, "_data_done"}, data_done, !v.instr);
        chk1({t, "_done_read"}, mem_read, 1'b0);
        chk1({t, "_done_write"}, mem_write, 1'b0);
        if (v.instr) chk32({t, "_instr_rdata"}, instr_rdata, v.exp_port_rdata);
        else         chk32({t, "_data_rdata"}, data_rdata, v.exp_port_rdata);
        step();
        chk1({t, "_post_idone"}, instr_done, 1'b0);
        chk1({t, "_post_ddone"}, data_done, 1'b0);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic          m_busy, m_port, m_wr, m_idone, m_ddone;
    logic [31:0]   m_addr, m_wdata, m_irdata, m_drdata;
    logic [3:0]    m_be;
    int            m_streak;       // consecutive contests lost by the fetch port
    int            m_ngrant_i, m_ngrant_d, n_dut_idone, n_dut_ddone;
    logic          i_act, d_act;
    logic [AW+1:0] exp_q[$];       // {port, write, address} of each granted transfer
    logic          pend_done_q[$]; // port owed a done pulse

    task automatic model_init();
        m_busy = 0; m_port = 0; m_wr = 0; m_idone = 0; m_ddone = 0;
        m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_be = 0;
        m_streak = 0; m_ngrant_i = 0; m_ngrant_d = 0; n_dut_idone = 0; n_dut_ddone = 0;
        i_act = 0; d_act = 0;
        exp_q.delete();
        pend_done_q.delete();
    endtask

    task automatic rand_cycle(input bit allow_new);
        logic          ip, dp, give_instr, nid, ndd;
        logic [AW+1:0] e;
        int            kind;
        // stimulus: requesters hold a request until its done cycle
        if (m_idone) i_act = 0;
        if (m_ddone) d_act = 0;
        if (!allow_new) begin
            i_act = 0;
            d_act = 0;
        end
        if (!i_act && allow_new && $urandom_range(0, 2) == 0) begin
            i_act      = 1;
            instr_addr = $urandom() & 32'hFFFF_FFFC;
        end else if (m_busy && !m_port) begin
            instr_addr = $urandom();
        end
        if (!d_act && allow_new && $urandom_range(0, 2) == 0) begin
            d_act           = 1;
            kind            = int'($urandom_range(0, 2));
            data_read       = (kind != 1);
            data_write      = (kind != 0);
            data_addr       = $urandom();
            data_wdata      = $urandom();
            data_byteenable = 4'($urandom());
        end else if (m_busy && m_port) begin
            data_addr       = $urandom();
            data_wdata      = $urandom();
            data_byteenable = 4'($urandom());
        end
        instr_req = i_act;
        if (!d_act) begin
            data_read  = 0;
            data_write = 0;
        end
        mem_waitrequest = allow_new ? ($urandom_range(0, 3) == 0) : 1'b0;
        mem_readdata    = $urandom();

        // outputs vs model
        chk1("rnd_mem_read", mem_read, m_busy && !m_wr);
        chk1("rnd_mem_write", mem_write, m_busy && m_wr);
        if (m_busy) begin
            chk32("rnd_mem_addr", mem_address, m_addr);
            chk32("rnd_mem_be", 32'(mem_byteenable), 32'(m_be));
            if (m_wr) chk32("rnd_mem_wdata", mem_writedata, m_wdata);
        end
        chk1("rnd_instr_done", instr_done, m_idone);
        chk1("rnd_data_done", data_done, m_ddone);
        chk32("rnd_instr_rdata", instr_rdata, m_irdata);
        chk32("rnd_data_rdata", data_rdata, m_drdata);

        // scoreboard: each done answers exactly one completed bus transfer
        if (instr_done || data_done) begin
            chk1("sb_done_has_xfer", pend_done_q.size() > 0, 1'b1);
            if (pend_done_q.size() > 0) chk1("sb_done_port", data_done, pend_done_q.pop_front());
        end
        n_dut_idone += int'(instr_done);
        n_dut_ddone += int'(data_done);
        if ((mem_read || mem_write) && !mem_waitrequest) begin
            chk1("sb_xfer_was_granted", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("sb_xfer_addr", mem_address, e[AW-1:0]);
                chk1("sb_xfer_dir", mem_write, e[AW]);
                pend_done_q.push_back(e[AW+1]);
            end
        end

        // model advance on this cycle's inputs
        nid = 0;
        ndd = 0;
        if (!m_busy) begin
            ip = instr_req;
            dp = data_read | data_write;
            give_instr = ip && (!dp || m_streak >= STARVE);
            if (give_instr) begin
                m_busy = 1; m_port = 0; m_wr = 0; m_addr = instr_addr; m_be = 4'hF;
                m_streak = 0;
                m_ngrant_i++;
                exp_q.push_back({1'b0, 1'b0, instr_addr});
            end else if (dp) begin
                m_busy = 1; m_port = 1; m_wr = data_write; m_addr = data_addr;
                m_wdata = data_wdata; m_be = data_byteenable;
                if (ip) m_streak++;
                m_ngrant_d++;
                exp_q.push_back({1'b1, data_write, data_addr});
            end
        end else if (!mem_waitrequest) begin
            m_busy = 0;
            if (!m_port) begin
                nid = 1;
                m_irdata = mem_readdata;
            end else begin
                ndd = 1;
                if (!m_wr) m_drdata = mem_readdata;
            end
        end
        m_idone = nid;
        m_ddone = ndd;
        step();
    endtask

    // ---------------- test sequence ----------------
    vec_t  vecs[6];
    byte   got[8];
    string exp_grants;
    int    n_grants;
    logic [31:0] r1, r2;

    initial begin
        vecs[0] = '{1, 0, 0, 32'hBFC0_0000, 32'h0, 4'h0, 0, 32'h3C1D_8000, 1, 0, 4'hF, 32'h3C1D_8000};
        vecs[1] = '{0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 32'hFFFF_FFFF, 0, 1, 4'b0011, 32'h0};
        vecs[2] = '{0, 1, 0, 32'h0000_2004, 32'h1111_2222, 4'hF, 1, 32'h1234_5678, 1, 0, 4'hF, 32'h1234_5678};
        vecs[3] = '{0, 1, 1, 32'h0000_3000, 32'hCAFE_F00D, 4'hC, 0, 32'hAAAA_5555, 0, 1, 4'hC, 32'h1234_5678};
        vecs[4] = '{1, 0, 0, 32'h8000_0180, 32'h0, 4'h3, 2, 32'h0000_000C, 1, 0, 4'hF, 32'h0000_000C};
        vecs[5] = '{0, 1, 0, 32'h0000_7FFC, 32'h0, 4'h1, 0, 32'h0000_00A5, 1, 0, 4'h1, 32'h0000_00A5};

        // reset state, checked with the clock running and reset held
        #12;
        chk_quiet("por");
        chk32("por_mem_be", 32'(mem_byteenable), 32'h0);
        chk32("por_mem_wdata", mem_writedata, 32'h0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // contention with both ports held continuously
        do_reset();
        instr_req = 1; instr_addr = 32'h100;
        data_read = 1; data_addr = 32'h200; data_byteenable = 4'hF;
        mem_waitrequest = 0;
        n_grants = 0;
        for (int c = 0; c < 60 && n_grants < 8; c++) begin
            step();
            chk1("contend_done_excl", instr_done && data_done, 1'b0);
            if (mem_read) begin
                got[n_grants] = (mem_address == 32'h100) ? "I" :
                                (mem_address == 32'h200) ? "D" : "?";
                n_grants++;
            end
        end
        chk32("contend_grant_count", n_grants, 8);
        exp_grants = "DDDIDDDI";
        for (int i = 0; i < 8; i++)
            chk32($sformatf("contend_grant%0d", i), 32'(got[i]), 32'(exp_grants[i]));
        clear_inputs();
        step();
        step();

        // reset in the middle of a stalled write
        do_reset();
        data_write = 1; data_addr = 32'h4000; data_wdata = 32'h55AA_55AA; data_byteenable = 4'hF;
        mem_waitrequest = 1;
        step();
        chk1("rstmid_write_on_bus", mem_write, 1'b1);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk1("rstmid_write_dropped", mem_write, 1'b0);
        chk32("rstmid_addr_cleared", mem_address, 32'h0);
        chk32("rstmid_wdata_cleared", mem_writedata, 32'h0);
        clear_inputs();
        step();
        chk1("rstmid_no_done_a", data_done, 1'b0);
        step();
        chk1("rstmid_no_done_b", data_done, 1'b0);
        reset = 1'b1;
        chk_quiet("rstmid_release");
        run_vec('{0, 1, 0, 32'h0000_4004, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1, 0, 4'hF, 32'h0BAD_F00D}, 6);

        // back-to-back fetches: request kept high through the done cycle
        r1 = $urandom();
        r2 = $urandom();
        instr_req = 1; instr_addr = 32'h400; mem_waitrequest = 0;
        step();
        chk1("b2b_first_read", mem_read, 1'b1);
        chk32("b2b_first_addr", mem_address, 32'h400);
        mem_readdata = r1;
        step();
        chk1("b2b_first_done", instr_done, 1'b1);
        chk32("b2b_first_rdata", instr_rdata, r1);
        chk1("b2b_gap_read", mem_read, 1'b0);
        instr_addr = 32'h404;
        step();
        chk1("b2b_second_read", mem_read, 1'b1);
        chk32("b2b_second_addr", mem_address, 32'h404);
        chk1("b2b_second_nodone", instr_done, 1'b0);
        mem_readdata = r2;
        step();
        chk1("b2b_second_done", instr_done, 1'b1);
        chk32("b2b_second_rdata", instr_rdata, r2);
        instr_req = 0;
        step();
        chk1("b2b_quiet_read", mem_read, 1'b0);
        chk1("b2b_quiet_done", instr_done, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        model_init();
        for (int c = 0; c < 2000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 10; c++) rand_cycle(1'b0);
        chk32("sb_exp_q_drained", exp_q.size(), 0);
        chk32("sb_done_q_drained", pend_done_q.size(), 0);
        chk32("sb_instr_done_count", n_dut_idone, m_ngrant_i);
        chk32("sb_data_done_count", n_dut_ddone, m_ngrant_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, the maximum number of consecutive contested grants to the data port before the instruction port wins.
REQ-002 SHALL have parameter ADDR_W, default 32, the address width of both ports and of the bus.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL provide ports instr_req (in, 1), instr_addr (in, ADDR_W), instr_rdata (out, 32) and instr_done (out, 1) for the fetch port.
REQ-006 SHALL provide ports data_read (in, 1), data_write (in, 1), data_addr (in, ADDR_W), data_wdata (in, 32), data_byteenable (in, 4), data_rdata (out, 32) and data_done (out, 1) for the load/store port.
REQ-007 SHALL provide bus ports mem_address (out, ADDR_W), mem_read (out, 1), mem_write (out, 1), mem_writedata (out, 32), mem_byteenable (out, 4), mem_readdata (in, 32) and mem_waitrequest (in, 1).

Function
REQ-008 SHALL implement FSM states IDLE, INSTR_XFER and DATA_XFER.
REQ-009 SHALL treat a request as pending when, sampled in IDLE, instr_req=1 or data_read|data_write=1.
REQ-010 SHALL, on a rising edge in IDLE, latch address, wdata, byteenable and direction of the granted request, then enter that port's XFER state.
REQ-011 SHALL, with only one port pending, grant that port.
REQ-012 SHALL, with both ports pending, grant data unless the contested-grant counter equals STARVE_LIMIT; in that case grant instr and clear the counter.
REQ-013 SHALL increment the contested-grant counter on each contested data grant, saturating at STARVE_LIMIT, and clear it on any instr grant.
REQ-014 SHALL, in an XFER state, drive the mem_* outputs from the latched values only; it SHALL force mem_read=mem_write=0 in IDLE.
REQ-015 SHALL drive mem_byteenable=4'hF and mem_read=1 for instruction transfers.
REQ-016 SHALL hold the bus outputs stable while mem_waitrequest=1, with no timeout.
REQ-017 SHALL complete a transfer on the first XFER cycle with mem_waitrequest=0; at that edge it returns to IDLE and captures mem_readdata into the port's rdata register (reads only).
REQ-018 SHALL pulse the port's done output high for exactly the one cycle after completion; rdata SHALL hold its value until the next completed read on that port.
REQ-019 SHALL give a minimum latency of request in cycle 0, bus access in cycle 1 and done in cycle 2; each wait cycle adds one cycle.
REQ-020 SHALL treat a request still asserted during its done cycle as a new request; requesters drop it in that cycle unless they want another transfer.
REQ-021 SHALL ignore request-input changes while in an XFER state.
REQ-022 SHALL resolve data_read=1 and data_write=1 together as a write; the read is dropped and not re-issued.
REQ-023 SHALL never assert mem_read and mem_write together, and SHALL never assert both done outputs in the same cycle.

Reset
REQ-024 SHALL, while reset=0, immediately force state IDLE, all mem_* outputs to 0, both done outputs to 0, both rdata outputs to 0 and the counter to 0.
REQ-025 SHALL abort any in-flight transfer on reset with no done pulse; the requester re-issues it after reset.
REQ-026 SHALL accept requests from the first rising edge with reset=1.

Verification
REQ-027 Single fetch: instr_req=1, instr_addr=0xBFC00000, waitrequest=0 -> mem_read=1 with mem_address=0xBFC00000 in cycle 1; instr_done=1 and instr_rdata=mem_readdata in cycle 2.
REQ-028 Wait states: data_write=1, addr=0x1000, wdata=0xDEADBEEF, byteenable=4'b0011, waitrequest=1 for 3 cycles -> mem_* outputs stable for 4 cycles; data_done one cycle after waitrequest falls.
REQ-029 Contention and starvation: instr_req and data_read held continuously with STARVE_LIMIT=3 -> grant sequence D,D,D,I,D,D,D,I.
REQ-030 Simultaneous read and write: data_read=data_write=1 -> only mem_write=1 asserted; data_rdata unchanged.
REQ-031 Reset mid-transfer: reset=0 during DATA_XFER with waitrequest=1 -> mem_write=0 with no clock edge; no data_done; first post-reset request is served normally.
REQ-032 Back-to-back: instr_req held through instr_done -> second fetch on bus the cycle after done; scoreboard checks every done matches exactly one bus transfer.
